cart: RTL and testbench

Cartridge slot model for the Super Cassette Vision core. It holds up to 128 KiB of cartridge ROM, loaded through an init port, plus up to 8 KiB of cartridge RAM. It decodes the CPU's 32 KiB cartridge window (CPU 0x8000–0xFF7F, chip-selected externally) through a selectable mapper with bank bits taken from CPU port C. It sits on the CPU data bus beside the boot ROM, work RAM and VDC.

---
 rtl/cart.sv | 96 +++++++++
 tb/tb_cart.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cart.sv
// Super Cassette Vision cartridge slot: init-loaded ROM, optional RAM,
// and the mapper that decodes the CPU cartridge window.
package cart_pkg;
   typedef enum logic [2:0] {
      ROM8K         = 3'd0,
      ROM16K        = 3'd1,
      ROM32K        = 3'd2,
      ROM32K_RAM8K  = 3'd3,
      ROM64K        = 3'd4,
      ROM128K       = 3'd5,
      ROM128K_RAM4K = 3'd6,
      RSVD          = 3'd7
   } mapper_t;
endpackage

module cart
   import cart_pkg::*;
#(
   parameter int ROM_AW = 17,
   parameter int RAM_AW = 13
) (
   input  logic              CLK,
   input  logic              RESB,
   input  logic [ROM_AW-1:0] INIT_ADDR,
   input  logic [7:0]        INIT_DATA,
   input  logic              INIT_VALID,
   input  mapper_t           MAPPER,
   input  logic [14:0]       A,
   input  logic [7:0]        DB_I,
   output logic [7:0]        DB_O,
   output logic              DB_OE,
   input  logic              CSB,
   input  logic              RDB,
   input  logic              WRB,
   input  logic [1:0]        PC
);

   logic [7:0] rom [2**ROM_AW];
   logic [7:0] ram [2**RAM_AW];

   logic [16:0]       rom_full;
   logic [12:0]       ram_full;
   logic              ram_sel;
   logic [ROM_AW-1:0] rom_a;
   logic [RAM_AW-1:0] ram_a;
   logic              ram_we;
   logic [7:0]        dreg;

   always_comb begin
      rom_full = {2'b00, A};
      ram_full = A[12:0];
      ram_sel  = 1'b0;
      unique case (MAPPER)
         ROM8K:   rom_full = {4'b0000, A[12:0]};
         ROM16K:  rom_full = {3'b000, A[13:0]};
         ROM32K:  ;
         ROM32K_RAM8K:
            ram_sel = (A[14:13] == 2'b11) & PC[0];
         ROM64K:  rom_full = {1'b0, PC[0], A};
         ROM128K: rom_full = {PC, A};
         ROM128K_RAM4K: begin
            rom_full = {PC, A};
            ram_full = {1'b0, A[11:0]};
            ram_sel  = (A[14:12] == 3'b111) & PC[1];
         end
         RSVD:    ;
      endcase
   end

   assign rom_a = rom_full[ROM_AW-1:0];
   assign ram_a = ram_full[RAM_AW-1:0];

   // Writes are gated by reset so a write strobe held through reset is lost.
   assign ram_we = RESB & ~CSB & ~WRB & ram_sel;

   always_ff @(posedge CLK) begin
      if (INIT_VALID)
         rom[INIT_ADDR] <= INIT_DATA;
   end

   always_ff @(posedge CLK) begin
      if (ram_we)
         ram[ram_a] <= DB_I;
   end

   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB)
         dreg <= '0;
      else
         dreg <= ram_sel ? ram[ram_a] : rom[rom_a];
   end

   assign DB_OE = RESB & ~CSB & ~RDB;
   assign DB_O  = DB_OE ? dreg : 8'hFF;

endmodule

// File: tb/tb_cart.sv
// Self-checking bench for cart: memory-level reference model plus
// directed reads and writes with hand-computed values.
module tb_cart;
   import cart_pkg::*;

   logic        CLK;
   logic        RESB;
   logic [16:0] INIT_ADDR;
   logic [7:0]  INIT_DATA;
   logic        INIT_VALID;
   mapper_t     MAPPER;
   logic [14:0] A;
   logic [7:0]  DB_I;
   logic [7:0]  DB_O;
   logic        DB_OE;
   logic        CSB;
   logic        RDB;
   logic        WRB;
   logic [1:0]  PC;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 0;

   cart dut (
      .CLK(CLK), .RESB(RESB),
      .INIT_ADDR(INIT_ADDR), .INIT_DATA(INIT_DATA),
      .INIT_VALID(INIT_VALID), .MAPPER(MAPPER),
      .A(A), .DB_I(DB_I), .DB_O(DB_O), .DB_OE(DB_OE),
      .CSB(CSB), .RDB(RDB), .WRB(WRB), .PC(PC)
   );

   initial begin
      CLK = 0;
      forever #5 CLK = ~CLK;
   end

   function automatic void check(input string n,
                                 input logic [7:0] act,
                                 input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endfunction

   // Reference model: sparse memories, only written locations are known
   logic [7:0] mrom [int];
   logic [7:0] mram [int];
   logic [7:0] mreg;
   bit         mknown;

   function automatic void decode(input int m, input int a, input int pc,
                                  output bit is_ram, output int idx);
      is_ram = 0;
      idx    = a;
      case (m)
         0: idx = a % 8192;
         1: idx = a % 16384;
         3: if (a >= 'h6000 && (pc % 2) == 1) begin
               is_ram = 1;
               idx    = a - 'h6000;
            end
         4: idx = (pc % 2) * 32768 + a;
         5: idx = pc * 32768 + a;
         6: if (a >= 'h7000 && pc >= 2) begin
               is_ram = 1;
               idx    = a - 'h7000;
            end else
               idx = pc * 32768 + a;
         default: idx = a;
      endcase
   endfunction

   always @(negedge RESB) begin
      mreg   = 8'h00;
      mknown = 1;
   end

   always @(posedge CLK) begin
      bit is_ram;
      int idx;
      decode(int'(MAPPER), int'(A), int'(PC), is_ram, idx);
      if (!RESB) begin
         mreg   = 8'h00;
         mknown = 1;
      end else begin
         if (is_ram) begin
            mknown = mram.exists(idx);
            mreg   = mknown ? mram[idx] : 8'h00;
         end else begin
            mknown = mrom.exists(idx);
            mreg   = mknown ? mrom[idx] : 8'h00;
         end
         if (!CSB && !WRB && is_ram)
            mram[idx] = DB_I;
      end
      if (INIT_VALID)
         mrom[int'(INIT_ADDR)] = INIT_DATA;
   end

   always @(negedge CLK) begin
      if (chk_on) begin
         logic eoe;
         eoe = RESB && !CSB && !RDB;
         check("model_oe", {7'b0, DB_OE}, {7'b0, eoe});
         if (!eoe)
            check("model_idle", DB_O, 8'hFF);
         else if (mknown)
            check("model_data", DB_O, mreg);
      end
   end

   function automatic logic [7:0] pat(input int i);
      return 8'((i % 256) + (i / 256) * 3);
   endfunction

   task automatic load(input int addr, input logic [7:0] d);
      @(posedge CLK); #2;
      INIT_ADDR  = 17'(addr);
      INIT_DATA  = d;
      INIT_VALID = 1;
   endtask

   task automatic rd(input string n, input logic [14:0] a,
                     input logic [7:0] exp);
      @(posedge CLK); #2;
      A = a; CSB = 0; RDB = 0; WRB = 1;
      @(posedge CLK); #1;
      check({n, "_oe"}, {7'b0, DB_OE}, 8'h01);
      check(n, DB_O, exp);
   endtask

   task automatic wr(input logic [14:0] a, input logic [7:0] d);
      @(posedge CLK); #2;
      A = a; DB_I = d; CSB = 0; WRB = 0; RDB = 1;
      @(posedge CLK); #2;
      WRB = 1; CSB = 1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      RESB = 0; CSB = 1; RDB = 1; WRB = 1;
      INIT_VALID = 0; INIT_ADDR = 0; INIT_DATA = 0;
      MAPPER = ROM32K; PC = 0; A = 0; DB_I = 0;
      #1;
      check("reset_oe", {7'b0, DB_OE}, 8'h00);
      check("reset_dbo", DB_O, 8'hFF);
      repeat (2) @(posedge CLK);
      #2 RESB = 1;
      chk_on = 1;

      for (int i = 0; i < 32768; i++)
         load(i, pat(i));
      load('h00010, 8'h5A);
      load('h18000, 8'hC3);
      load('h09234, 8'h77);
      @(posedge CLK); #2 INIT_VALID = 0;

      MAPPER = ROM32K;
      rd("m2_1234", 15'h1234, 8'h6A);
      #1 CSB = 1;
      #1;
      check("desel_oe", {7'b0, DB_OE}, 8'h00);
      check("desel_dbo", DB_O, 8'hFF);

      MAPPER = ROM8K;
      rd("m0_mirror", 15'h6010, 8'h5A);
      MAPPER = ROM16K;
      rd("m1_mirror", 15'h4010, 8'h5A);

      MAPPER = ROM128K; PC = 2'b11;
      rd("m5_pc3", 15'h0000, 8'hC3);
      PC = 2'b00;
      rd("m5_pc0", 15'h0000, 8'h00);

      MAPPER = ROM64K; PC = 2'b01;
      rd("m4_pc1", 15'h1234, 8'h77);
      PC = 2'b10;
      rd("m4_pc2", 15'h1234, 8'h6A);

      MAPPER = ROM32K_RAM8K; PC = 2'b01;
      wr(15'h6000, 8'hA5);
      rd("m3_ram", 15'h6000, 8'hA5);
      PC = 2'b00;
      rd("m3_rom", 15'h6000, 8'h20);
      wr(15'h6000, 8'h99);
      rd("m3_romwr", 15'h6000, 8'h20);
      PC = 2'b01;
      rd("m3_ram2", 15'h6000, 8'hA5);

      MAPPER = ROM128K_RAM4K; PC = 2'b10;
      wr(15'h7FFF, 8'h3C);
      rd("m6_ram", 15'h7FFF, 8'h3C);
      PC = 2'b00;
      rd("m6_rom", 15'h7FFF, 8'h7C);
      MAPPER = ROM32K_RAM8K; PC = 2'b01;
      rd("m3_alias", 15'h6FFF, 8'h3C);

      MAPPER = RSVD; PC = 2'b11;
      rd("m7_1234", 15'h1234, 8'h6A);

      MAPPER = ROM32K_RAM8K; PC = 2'b01;
      rd("pre_reset", 15'h6000, 8'hA5);
      #1 RESB = 0;
      #1;
      check("rst_oe", {7'b0, DB_OE}, 8'h00);
      check("rst_dbo", DB_O, 8'hFF);
      RDB = 1; WRB = 0; DB_I = 8'h11;
      @(posedge CLK); #2;
      WRB = 1; RDB = 0; RESB = 1;
      #1;
      check("rel_oe", {7'b0, DB_OE}, 8'h01);
      check("rel_clr", DB_O, 8'h00);
      @(posedge CLK); #1;
      check("rel_data", DB_O, 8'hA5);

      @(posedge CLK); #2 CSB = 1; RDB = 1;
      repeat (3) @(posedge CLK);
      chk_on = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
